// File: rtl/etm_div_seq.sv
// etm_div_seq: sequential unsigned error-tolerant divider.
// Upper quotient bits come from restoring division, one bit per clock.
// In ETM mode the remaining low bits are filled in a single cycle:
// all ones when the low quotient would be nonzero, else all zeros.
module etm_div_seq #(
  parameter int WIDTH      = 8,
  parameter int EXACT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  localparam int LOW = WIDTH - EXACT_BITS;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int XW  = 2 * WIDTH;
  localparam logic            ETM_OK   = 1'(EXACT_BITS < WIDTH);
  localparam logic [XW-1:0]   LOW_MASK = (XW'(1) << LOW) - XW'(1);
  localparam logic [CW-1:0]   N_EXACT  = CW'(WIDTH);
  localparam logic [CW-1:0]   N_ETM    = CW'(EXACT_BITS);
  localparam logic [IW-1:0]   TOP_IDX  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXACT  = 2'd1,
    S_APPROX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             approx_q, approx_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dbz_q, dbz_d;
  logic             ov_q, ov_d;
  logic             ir_q, ir_d;

  logic [WIDTH:0]   t_s;
  logic [WIDTH-1:0] diff_s;
  logic             t_ge_s;
  logic [XW-1:0]    x_s;
  logic             x_ge_s;

  // Datapath: one restoring step and the wide low-bit comparison for the ETM fill
  always_comb begin
    t_s    = {r_q, dvd_q[idx_q]};
    t_ge_s = (t_s >= {1'b0, dvs_q});
    // T < 2*divisor, so the true difference always fits in WIDTH bits
    diff_s = t_s[WIDTH-1:0] - dvs_q;
    x_s    = ({{WIDTH{1'b0}}, r_q} << LOW) | ({{WIDTH{1'b0}}, dvd_q} & LOW_MASK);
    x_ge_s = (x_s >= {{WIDTH{1'b0}}, dvs_q});
  end

  // Next-state and next-output logic for the IDLE/EXACT/APPROX/DONE sequencer
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    approx_d = approx_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    quot_d   = quot_q;
    dbz_d    = dbz_q;
    ov_d     = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d    = dividend;
          dvs_d    = divisor;
          approx_d = approx_en;
          r_d      = {WIDTH{1'b0}};
          q_d      = {WIDTH{1'b0}};
          idx_d    = TOP_IDX;
          dbz_d    = 1'b0;
          if (divisor == {WIDTH{1'b0}}) begin
            q_d     = {WIDTH{1'b1}};
            quot_d  = {WIDTH{1'b1}};
            dbz_d   = 1'b1;
            ov_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = (approx_en && ETM_OK) ? N_ETM : N_EXACT;
            state_d = S_EXACT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXACT: begin
        if (t_ge_s) begin
          r_d        = diff_s;
          q_d[idx_q] = 1'b1;
        end else begin
          r_d        = t_s[WIDTH-1:0];
          q_d[idx_q] = 1'b0;
        end
        cnt_d = cnt_q - CW'(1);
        idx_d = idx_q - IW'(1);
        if (cnt_q == CW'(1)) begin
          if (approx_q && ETM_OK) begin
            state_d = S_APPROX;
          end else begin
            quot_d  = q_d;
            ov_d    = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_EXACT;
        end
      end
      S_APPROX: begin
        if (x_ge_s) begin
          q_d = q_q | LOW_MASK[WIDTH-1:0];
        end else begin
          q_d = q_q;
        end
        quot_d  = q_d;
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        ov_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    ir_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dvd_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      approx_q <= 1'b0;
      r_q      <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      idx_q    <= {IW{1'b0}};
      quot_q   <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
      ov_q     <= 1'b0;
      ir_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      approx_q <= approx_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      quot_q   <= quot_d;
      dbz_q    <= dbz_d;
      ov_q     <= ov_d;
      ir_q     <= ir_d;
    end
  end

  assign in_ready    = ir_q;
  assign out_valid   = ov_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_etm_div_seq.sv
// tb_etm_div_seq: directed self-checking bench for etm_div_seq with an
// arithmetic reference model of the ETM quotient and result latency.
module tb_etm_div_seq;

  localparam int W  = 8;
  localparam int EB = 4;
  localparam int L  = W - EB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         approx_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic         div_by_zero;

  int           checks = 0;
  int           errors = 0;

  logic         mon_en = 1'b0;
  int           cyc = 0;
  int           exp_lat = 0;
  logic [W-1:0] exp_q = '0;
  logic         exp_dbz = 1'b0;

  etm_div_seq #(.WIDTH(W), .EXACT_BITS(EB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .approx_en  (approx_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer quotient, then low L bits forced to all ones if any is set
  function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ae);
    int ex, hi, lo, mask, res;
    if (b == '0) return {W{1'b1}};
    ex = int'(a) / int'(b);
    if (!ae || EB >= W) return ex[W-1:0];
    mask = (1 << L) - 1;
    hi   = ex >> L;
    lo   = ex & mask;
    res  = (hi << L) | ((lo != 0) ? mask : 0);
    return res[W-1:0];
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic ae);
    if (b == '0) return 0;
    if (ae && EB < W) return EB + 1;
    return W;
  endfunction

  // Compare process: every cycle of an operation, check handshake timing and result
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid_timing", 32'(out_valid), (cyc >= exp_lat) ? 32'd1 : 32'd0);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_valid) begin
          check("quotient", 32'(quotient), 32'(exp_q));
          check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
        end
        cyc = cyc + 1;
      end
    end
  end

  // One transaction; called and returning at a falling edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ae,
                        input int hold, input logic pulse, input logic [W-1:0] lit);
    int k;
    logic [W-1:0] mq;
    mq = model_q(a, b, ae);
    check("model_pin", 32'(mq), 32'(lit));
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    dividend  = a;
    divisor   = b;
    approx_en = ae;
    in_valid  = 1'b1;
    @(posedge clk);
    exp_q   = mq;
    exp_dbz = (b == '0);
    exp_lat = model_lat(b, ae);
    cyc     = 0;
    mon_en  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      if (pulse) begin
        in_valid = ~in_valid;
        dividend = 8'hA5;
        divisor  = 8'h00;
      end
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      mon_en   = 1'b0;
      in_valid = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        in_valid = (h % 2 == 0);
        dividend = 8'h5A;
        divisor  = 8'h00;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    mon_en = 1'b0;
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("quotient_hold", 32'(quotient), 32'(mq));
    check("dbz_hold", 32'(div_by_zero), 32'(exp_dbz));
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 8'd7,   1'b1, 0, 1'b0, 8'h1F);
    run_op(8'd200, 8'd7,   1'b0, 0, 1'b0, 8'h1C);
    run_op(8'd7,   8'd9,   1'b1, 0, 1'b0, 8'h00);
    run_op(8'd200, 8'd100, 1'b1, 0, 1'b0, 8'h0F);
    run_op(8'd255, 8'd1,   1'b1, 0, 1'b0, 8'hFF);
    run_op(8'd255, 8'd1,   1'b0, 0, 1'b0, 8'hFF);
    run_op(8'd128, 8'd8,   1'b1, 0, 1'b0, 8'h10);
    run_op(8'd37,  8'd0,   1'b0, 0, 1'b0, 8'hFF);
    run_op(8'd10,  8'd3,   1'b0, 0, 1'b0, 8'h03);
    run_op(8'd150, 8'd11,  1'b1, 6, 1'b1, 8'h0F);

    // Reset in the middle of an exact division, after two restoring steps
    dividend  = 8'd200;
    divisor   = 8'd7;
    approx_en = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("midrst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd100, 8'd10, 1'b0, 0, 1'b0, 8'h0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etm_div_seq.md
Name: etm_div_seq

Overview:
- Sequential unsigned error-tolerant divider. It is the inverse-operation partner of the ETM approximate multipliers in the multiplier library.
- Upper quotient bits are computed exactly by restoring division, one bit per clock.
- Lower quotient bits are resolved in a single cycle using the ETM rule: all ones if any low quotient is nonzero, else all zeros.
- It sits behind a valid/ready handshake in the CNN datapath, used for normalisation and scaling.

Parameters:
- WIDTH, 8, width of dividend, divisor and quotient.
- EXACT_BITS, 4, number of MSB quotient bits computed exactly (1..WIDTH). When equal to WIDTH the divider is always exact.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- approx_en  input  1  1 = ETM mode, 0 = fully exact. Sampled at accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: IDLE. quotient=0, div_by_zero=0, out_valid=0, in_ready=1 (in_ready = state==IDLE). Internal remainder, counter and operand registers are cleared.
- Reset mid-operation aborts immediately. No result is produced, and the block returns to IDLE.
- FSM states: IDLE, EXACT, APPROX, DONE.
- IDLE:
  - Accept when in_valid & in_ready. Latch dividend, divisor and approx_en; clear remainder R and quotient Q.
  - If divisor==0: go to DONE with Q=all ones, div_by_zero=1.
  - Otherwise go to EXACT, with the counter set to N. N = EXACT_BITS if (approx_en && EXACT_BITS<WIDTH), else WIDTH.
- EXACT, one restoring step per clock, bit index i counting down from WIDTH-1:
  - T = {R, dividend[i]}, WIDTH+1 bits.
  - If T >= divisor: R = T - divisor and Q[i]=1. Otherwise R = T[WIDTH-1:0] and Q[i]=0.
  - After N steps: go to APPROX if ETM mode is active, else DONE.
- APPROX, one clock:
  - L = WIDTH - EXACT_BITS.
  - X = {R, dividend[L-1:0]}, WIDTH+L bits.
  - Q[L-1:0] = all ones if X >= divisor, else 0. Then go to DONE.
  - This guarantees approx quotient >= exact quotient, and exact when the low quotient is 0.
- DONE:
  - out_valid=1. quotient and div_by_zero are held stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE. out_valid drops the next cycle; quotient holds its last value.
- Latency, with accept at edge 0:
  - Exact mode: out_valid is high after edge WIDTH.
  - ETM mode: out_valid is high after edge EXACT_BITS+1.
  - Divide-by-zero: out_valid is high after edge 0.
- Throughput: no overlap. in_ready=0 in EXACT, APPROX and DONE. in_valid outside IDLE is ignored; operands must be held by the source until accepted.
- Combinational out_ready to in_ready path: none. Acceptance of the next operands happens at the earliest one cycle after the DONE handshake.
- div_by_zero clears at the next accept.
- Width rules:
  - All arithmetic is unsigned.
  - The comparator is WIDTH+1 bits in EXACT and WIDTH+L bits in APPROX.
  - R < divisor is always maintained, so no overflow.

Test Plan:
- ETM mode (approx_en=1), WIDTH=8, EXACT_BITS=4, 200/7 -> quotient=0x1F (exact 0x1C), div_by_zero=0, out_valid 5 cycles after accept.
- Exact mode (approx_en=0), same operands 200/7 -> quotient=0x1C, out_valid 8 cycles after accept.
- ETM mode corner values:
  - 7/9 -> 0x00 (low fill stays zero).
  - 200/100 -> 0x0F.
  - 255/1 -> 0xFF, matches exact.
- Divide-by-zero: 37/0 -> quotient=0xFF, div_by_zero=1, out_valid the cycle after accept. The next accepted 10/3 (exact mode) -> 0x03, div_by_zero=0.
- Backpressure: out_ready held low 6 cycles in DONE -> out_valid, quotient and div_by_zero stable. in_ready=0 throughout, and in_valid pulses are ignored.
- Reset mid-EXACT: assert rst_n low at step 2 -> outputs immediately 0, in_ready=1. After release, 100/10 exact -> 0x0A.
